// File: rtl/sim_tape_reader.sv
// Photoelectric tape reader model: linear 5-bit tape buffer played out over a valid/ready port.
// Optional replay of the tape from entry 0 is enabled by defining SIM_TAPE_REWIND_EN.
module sim_tape_reader #(
    parameter int DEPTH      = 256,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_val,
    input  logic [4:0]  load_data,
    output logic        load_rdy,
    input  logic        tape_clear,
    input  logic        tape_rewind,
    input  logic        input_rdy,
    output logic        input_val,
    output logic [4:0]  input_data,
    output logic        tape_end,
    output logic [15:0] chars_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [4:0]     data_q, data_d;
    logic [15:0]    chars_q, chars_d;
    logic           wr_en;
    logic [4:0]     mem_q [DEPTH];

`ifndef SIM_TAPE_REWIND_EN
    logic rewind_unused;
    assign rewind_unused = tape_rewind;
`endif

    assign load_rdy   = (wr_q != FULL);
    assign input_val  = (state_q == PRESENT);
    assign input_data = data_q;
    assign tape_end   = (rd_q == wr_q);
    assign chars_sent = chars_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        gap_d   = gap_q;
        data_d  = data_q;
        chars_d = chars_q;
        wr_en   = 1'b0;

        if (load_val && load_rdy) begin
            wr_en = 1'b1;
            wr_d  = wr_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (rd_q != wr_q) begin
                    state_d = PRESENT;
                    data_d  = mem_q[rd_q[AW-1:0]];
                end
            end
            PRESENT: begin
                if (input_rdy) begin
                    rd_d = rd_q + 1'b1;
                    if (chars_q != 16'hffff) begin
                        chars_d = chars_q + 16'd1;
                    end
                    if (GAP_CYCLES == 0) begin
                        // Zero gap: chain straight into the next stored character.
                        if (rd_d != wr_q) begin
                            data_d = mem_q[rd_d[AW-1:0]];
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SIM_TAPE_REWIND_EN
        if (tape_rewind) begin
            rd_d    = '0;
            state_d = IDLE;
            gap_d   = '0;
        end
`endif

        if (tape_clear) begin
            wr_d    = '0;
            rd_d    = '0;
            state_d = IDLE;
            gap_d   = '0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            chars_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            chars_q <= chars_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_q[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_sim_tape_reader.sv
// Self-checking bench for sim_tape_reader against a queue-based tape model.
// Covers load/read, stall hold, full buffer, clear, rewind and zero-gap streaming.
module tb_sim_tape_reader;

    localparam int DEPTH  = 256;
    localparam int GAP    = 4;
    localparam int DEPTH1 = 8;

    logic        clk = 1'b0;
    logic        reset, load_val, tape_clear, tape_rewind, input_rdy;
    logic [4:0]  load_data;
    logic        load_rdy, input_val, tape_end;
    logic [4:0]  input_data;
    logic [15:0] chars_sent;

    logic        reset1, load_val1, tape_clear1, tape_rewind1, input_rdy1;
    logic [4:0]  load_data1;
    logic        load_rdy1, input_val1, tape_end1;
    logic [4:0]  input_data1;
    logic [15:0] chars_sent1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [4:0] tape_m[$];
    logic [4:0] rx_d[$];
    int         rx_c[$];
    logic [4:0] rx1_d[$];
    int         rx1_c[$];

    always #5 clk = ~clk;

    sim_tape_reader #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .load_val(load_val), .load_data(load_data), .load_rdy(load_rdy),
        .tape_clear(tape_clear), .tape_rewind(tape_rewind),
        .input_rdy(input_rdy), .input_val(input_val), .input_data(input_data),
        .tape_end(tape_end), .chars_sent(chars_sent)
    );

    sim_tape_reader #(.DEPTH(DEPTH1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset1),
        .load_val(load_val1), .load_data(load_data1), .load_rdy(load_rdy1),
        .tape_clear(tape_clear1), .tape_rewind(tape_rewind1),
        .input_rdy(input_rdy1), .input_val(input_val1), .input_data(input_data1),
        .tape_end(tape_end1), .chars_sent(chars_sent1)
    );

    // Inputs change at posedge+1, so the values seen here are what the next edge samples.
    always @(negedge clk) begin
        cyc++;
        if (!reset && !tape_clear && !tape_rewind && input_val && input_rdy) begin
            rx_d.push_back(input_data);
            rx_c.push_back(cyc);
        end
        if (!reset1 && !tape_clear1 && input_val1 && input_rdy1) begin
            rx1_d.push_back(input_data1);
            rx1_c.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; load_val = 1'b0; load_data = '0;
        tape_clear = 1'b0; tape_rewind = 1'b0; input_rdy = 1'b0;
        step(2);
        reset = 1'b0;
        tape_m.delete(); rx_d.delete(); rx_c.delete();
    endtask

    task automatic load_one(input logic [4:0] d, input bit rnd_rdy);
        load_val  = 1'b1;
        load_data = d;
        if (rnd_rdy) input_rdy = 1'($urandom_range(0, 1));
        step(1);
        if (tape_m.size() < DEPTH) tape_m.push_back(d);
        load_val = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input bit rnd_rdy, input string nm);
        int k = 0;
        while (rx_d.size() < n && k < budget) begin
            if (rnd_rdy) input_rdy = 1'($urandom_range(0, 1));
            step(1);
            k++;
        end
        input_rdy = 1'b0;
        if (rx_d.size() < n) begin
            n_err++;
            $display("FAIL %s timeout: got %0d chars, required %0d", nm, rx_d.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; input_rdy = 1'b1;
        step(1);
        do_reset();
        n_cmp++;
        if ({input_val, input_data, load_rdy, tape_end, chars_sent} !== {1'b0, 5'd0, 1'b1, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL reset: val=%b data=%0d lrdy=%b end=%b sent=%0d, required 0 0 1 1 0",
                     input_val, input_data, load_rdy, tape_end, chars_sent);
        end
    endtask

    task automatic test_basic();
        logic [4:0] seq[3];
        seq = '{5'd3, 5'd7, 5'd31};
        do_reset();
        input_rdy = 1'b1;
        foreach (seq[i]) load_one(seq[i], 1'b0);
        input_rdy = 1'b1;
        wait_rx(3, 60, 1'b0, "basic");
        step(GAP + 3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i < rx_d.size() && rx_d[i] !== seq[i]) begin
                n_err++;
                $display("FAIL basic_data[%0d]: got %0d, required %0d", i, rx_d[i], seq[i]);
            end
        end
        for (int i = 1; i < rx_c.size(); i++) begin
            n_cmp++;
            if (rx_c[i] - rx_c[i-1] < GAP + 1) begin
                n_err++;
                $display("FAIL basic_spacing[%0d]: got %0d, required >= %0d", i, rx_c[i] - rx_c[i-1], GAP + 1);
            end
        end
        n_cmp++;
        if (chars_sent !== 16'd3 || tape_end !== 1'b1 || input_val !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: sent=%0d end=%b val=%b, required 3 1 0", chars_sent, tape_end, input_val);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset();
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) load_one(5'($urandom), 1'b1);
            wait_rx(n, n * (GAP + 3) * 4 + 50, 1'b1, "random");
            step(GAP + 3);
            n_cmp++;
            if (rx_d.size() != tape_m.size()) begin
                n_err++;
                $display("FAIL random_count[%0d]: got %0d, required %0d", r, rx_d.size(), tape_m.size());
            end
            for (int i = 0; i < rx_d.size() && i < tape_m.size(); i++) begin
                n_cmp++;
                if (rx_d[i] !== tape_m[i]) begin
                    n_err++;
                    $display("FAIL random_data[%0d][%0d]: got %0d, required %0d", r, i, rx_d[i], tape_m[i]);
                end
            end
            n_cmp++;
            if (chars_sent !== 16'(tape_m.size()) || tape_end !== 1'b1) begin
                n_err++;
                $display("FAIL random_sent[%0d]: sent=%0d end=%b, required %0d 1", r, chars_sent, tape_end, tape_m.size());
            end
        end
    endtask

    task automatic test_hold();
        int k = 0;
        int bad = 0;
        do_reset();
        load_one(5'd5, 1'b0);
        while (!input_val && k < 10) begin step(1); k++; end
        for (int i = 0; i < 10; i++) begin
            if (input_val !== 1'b1 || input_data !== 5'd5) bad++;
            step(1);
        end
        n_cmp++;
        if (bad != 0 || rx_d.size() != 0) begin
            n_err++;
            $display("FAIL hold: %0d stalled cycles wrong, %0d accepted, required 0 0", bad, rx_d.size());
        end
        input_rdy = 1'b1;
        wait_rx(1, 5, 1'b0, "hold_accept");
        n_cmp++;
        if (rx_d.size() > 0 && rx_d[0] !== 5'd5) begin
            n_err++;
            $display("FAIL hold_data: got %0d, required 5", rx_d[0]);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) load_one(5'($urandom), 1'b0);
        n_cmp++;
        if (load_rdy !== 1'b0 || tape_m.size() != DEPTH) begin
            n_err++;
            $display("FAIL full_lrdy: load_rdy=%b, required 0", load_rdy);
        end
        input_rdy = 1'b1;
        wait_rx(DEPTH, DEPTH * (GAP + 3) + 50, 1'b0, "full_drain");
        input_rdy = 1'b1;
        step(30);
        input_rdy = 1'b0;
        n_cmp++;
        if (rx_d.size() != DEPTH || tape_end !== 1'b1) begin
            n_err++;
            $display("FAIL full_count: got %0d end=%b, required %0d 1", rx_d.size(), tape_end, DEPTH);
        end
        begin
            int bad = 0;
            for (int i = 0; i < rx_d.size() && i < DEPTH; i++) if (rx_d[i] !== tape_m[i]) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL full_data: %0d characters wrong, required 0", bad);
            end
        end
    endtask

    task automatic test_clear();
        logic [15:0] sent0;
        int k = 0;
        do_reset();
        input_rdy = 1'b1;
        load_one(5'd9, 1'b0);
        wait_rx(1, 20, 1'b0, "clear_pre");
        step(GAP + 2);
        load_one(5'd11, 1'b0);
        load_one(5'd12, 1'b0);
        while (!input_val && k < 10) begin step(1); k++; end
        sent0 = chars_sent;
        tape_clear = 1'b1;
        step(1);
        tape_clear = 1'b0;
        n_cmp++;
        if (input_val !== 1'b0 || tape_end !== 1'b1 || load_rdy !== 1'b1 || chars_sent !== 16'd1 || sent0 !== 16'd1) begin
            n_err++;
            $display("FAIL clear: val=%b end=%b lrdy=%b sent=%0d, required 0 1 1 1",
                     input_val, tape_end, load_rdy, chars_sent);
        end
        input_rdy = 1'b1;
        step(12);
        input_rdy = 1'b0;
        n_cmp++;
        if (rx_d.size() != 1 || chars_sent !== 16'd1) begin
            n_err++;
            $display("FAIL clear_after: got %0d chars sent=%0d, required 1 1", rx_d.size(), chars_sent);
        end
    endtask

    task automatic test_rewind();
        int exp_n;
        do_reset();
        input_rdy = 1'b1;
        load_one(5'd1, 1'b0);
        load_one(5'd2, 1'b0);
        input_rdy = 1'b1;
        wait_rx(2, 40, 1'b0, "rewind_pre");
        step(GAP + 4);
        tape_rewind = 1'b1;
        step(1);
        tape_rewind = 1'b0;
        input_rdy = 1'b1;
`ifdef SIM_TAPE_REWIND_EN
        exp_n = 4;
`else
        exp_n = 2;
`endif
        step(40);
        input_rdy = 1'b0;
        n_cmp++;
        if (rx_d.size() != exp_n || chars_sent !== 16'(exp_n)) begin
            n_err++;
            $display("FAIL rewind_count: got %0d sent=%0d, required %0d", rx_d.size(), chars_sent, exp_n);
        end
        for (int i = 0; i < rx_d.size() && i < exp_n; i++) begin
            n_cmp++;
            if (rx_d[i] !== 5'(i % 2 + 1)) begin
                n_err++;
                $display("FAIL rewind_data[%0d]: got %0d, required %0d", i, rx_d[i], i % 2 + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] seq[4];
        int k = 0;
        reset1 = 1'b1; load_val1 = 1'b0; load_data1 = '0;
        tape_clear1 = 1'b0; tape_rewind1 = 1'b0; input_rdy1 = 1'b0;
        step(2);
        reset1 = 1'b0;
        rx1_d.delete(); rx1_c.delete();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 5'($urandom);
            load_val1 = 1'b1; load_data1 = seq[i];
            step(1);
        end
        load_val1 = 1'b0;
        step(2);
        input_rdy1 = 1'b1;
        while (rx1_d.size() < 4 && k < 20) begin step(1); k++; end
        step(3);
        input_rdy1 = 1'b0;
        n_cmp++;
        if (rx1_d.size() != 4 || chars_sent1 !== 16'd4 || tape_end1 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_count: got %0d sent=%0d end=%b, required 4 4 1", rx1_d.size(), chars_sent1, tape_end1);
        end
        for (int i = 0; i < rx1_d.size() && i < 4; i++) begin
            n_cmp++;
            if (rx1_d[i] !== seq[i] || (i > 0 && rx1_c[i] - rx1_c[i-1] != 1)) begin
                n_err++;
                $display("FAIL b2b[%0d]: data=%0d gap=%0d, required %0d 1", i, rx1_d[i],
                         (i > 0) ? rx1_c[i] - rx1_c[i-1] : 1, seq[i]);
            end
        end
    endtask

    initial begin
        reset1 = 1'b1; load_val1 = 1'b0; load_data1 = '0;
        tape_clear1 = 1'b0; tape_rewind1 = 1'b0; input_rdy1 = 1'b0;
        reset = 1'b1; load_val = 1'b0; load_data = '0;
        tape_clear = 1'b0; tape_rewind = 1'b0; input_rdy = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_hold();
        test_full();
        test_clear();
        test_rewind();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
